// File: rtl/detector_pkg.sv
// detector_pkg: shared FSM state type, detector pattern and default widths for the 1011 stream controller
package detector_pkg;
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, REPORT} state_t;
  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-load MSB-first shift register with a down-counting bit index
// Ports: clk/reset (sync, active-high); load captures word_in; shift_en shifts left one bit;
//        serial_out is the current MSB; last_bit flags the bit at index 0.
module bit_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] word_in,
  output logic              serial_out,
  output logic              last_bit
);
  localparam int IW = $clog2(WORD_W);
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [IW-1:0] idx_q, idx_d;
  always_comb begin
    sr_d = load ? word_in : shift_en ? {sr_q[WORD_W-2:0], 1'b0} : sr_q;
    idx_d = load ? IW'(WORD_W - 1) : shift_en ? idx_q - 1'b1 : idx_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
      idx_q <= '0;
    end else begin
      sr_q <= sr_d;
      idx_q <= idx_d;
    end
  end
  assign serial_out = sr_q[WORD_W-1];
  assign last_bit = idx_q == '0;
endmodule

// File: rtl/detector_stream_ctrl.sv
// detector_stream_ctrl: feeds words MSB-first into a hybrid 1011 detector and reports per-word match counts
// Ports: clk/reset (sync, active-high); word_in/word_valid/word_ready producer handshake;
//        det_reset/det_din/det_mealy/det_moore detector link; match_count/count_valid/consist_err report.
module detector_stream_ctrl
  import detector_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              det_reset,
  output logic              det_din,
  input  logic              det_mealy,
  input  logic              det_moore,
  output logic [CNT_W-1:0]  match_count,
  output logic              count_valid,
  output logic              consist_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] mealy_q, mealy_d, moore_q, moore_d, match_count_q, match_count_d;
  logic count_valid_q, count_valid_d, consist_err_q, consist_err_d;
  logic accept, shifting, draining, serial_out, last_bit;
  assign accept = state_q == IDLE && word_valid;
  assign shifting = state_q == SHIFT;
  assign draining = state_q == DRAIN;
  bit_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .shift_en   (shifting),
    .word_in    (word_in),
    .serial_out (serial_out),
    .last_bit   (last_bit)
  );
  // Report registers load on the DRAIN->REPORT edge so they are already valid while count_valid is high;
  // the Moore side uses moore_d to include a hit on the final bit sampled during DRAIN.
  always_comb begin
    state_d = state_q == IDLE  ? (word_valid ? CLR : IDLE) :
              state_q == CLR   ? SHIFT :
              state_q == SHIFT ? (last_bit ? DRAIN : SHIFT) :
              state_q == DRAIN ? REPORT : IDLE;
    mealy_d = accept ? '0 : (shifting && det_mealy && mealy_q != CNT_MAX) ? mealy_q + 1'b1 : mealy_q;
    moore_d = accept ? '0 : ((shifting || draining) && det_moore && moore_q != CNT_MAX) ? moore_q + 1'b1 : moore_q;
    count_valid_d = draining;
    match_count_d = draining ? mealy_q : match_count_q;
    consist_err_d = draining ? mealy_q != moore_d : consist_err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mealy_q <= '0;
      moore_q <= '0;
      match_count_q <= '0;
      count_valid_q <= 1'b0;
      consist_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mealy_q <= mealy_d;
      moore_q <= moore_d;
      match_count_q <= match_count_d;
      count_valid_q <= count_valid_d;
      consist_err_q <= consist_err_d;
    end
  end
  assign word_ready = state_q == IDLE;
  assign det_reset = reset || state_q == CLR;
  assign det_din = shifting && serial_out;
  assign match_count = match_count_q;
  assign count_valid = count_valid_q;
  assign consist_err = consist_err_q;
endmodule

// File: tb/tb_detector_stream_ctrl.sv
// tb_detector_stream_ctrl: directed table-driven checks of the stream controller against a behavioural 1011 detector
module tb_detector_stream_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] wi8 = '0;
  logic wv8 = 1'b0, rdy8, dr8, din8, ml8, mo8, cv8, ce8, kill = 1'b0;
  logic [3:0] mc8;
  logic [15:0] wi16 = '0;
  logic wv16 = 1'b0, rdy16, dr16, din16, ml16, mo16, cv16, ce16;
  logic [1:0] mc16;

  detector_stream_ctrl #(.WORD_W(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .word_in(wi8), .word_valid(wv8), .word_ready(rdy8),
    .det_reset(dr8), .det_din(din8), .det_mealy(ml8), .det_moore(mo8),
    .match_count(mc8), .count_valid(cv8), .consist_err(ce8));
  detector_stream_ctrl #(.WORD_W(16), .CNT_W(2)) dut16 (
    .clk(clk), .reset(reset), .word_in(wi16), .word_valid(wv16), .word_ready(rdy16),
    .det_reset(dr16), .det_din(din16), .det_mealy(ml16), .det_moore(mo16),
    .match_count(mc16), .count_valid(cv16), .consist_err(ce16));

  // Behavioural hybrid 1011 detector: p = length of matched prefix, overlap allowed.
  function automatic logic [1:0] nxt(input logic [1:0] p, input logic b);
    return p == 2'd0 ? (b ? 2'd1 : 2'd0) : p == 2'd1 ? (b ? 2'd1 : 2'd2) :
           p == 2'd2 ? (b ? 2'd3 : 2'd0) : (b ? 2'd1 : 2'd2);
  endfunction
  logic [1:0] p8, p16;
  logic mq8, mq16;
  always @(posedge clk) begin
    if (dr8) begin p8 <= 2'd0; mq8 <= 1'b0; end
    else begin p8 <= nxt(p8, din8); mq8 <= ml8; end
    if (dr16) begin p16 <= 2'd0; mq16 <= 1'b0; end
    else begin p16 <= nxt(p16, din16); mq16 <= ml16; end
  end
  assign ml8 = p8 == 2'd3 && din8;
  assign mo8 = mq8 && !kill;
  assign ml16 = p16 == 2'd3 && din16;
  assign mo16 = mq16;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  int hs_cyc;
  task automatic send(input logic [7:0] w, input logic [3:0] ec, input logic ee, input bit fault, input bit toggle);
    int n;
    logic [7:0] bits;
    bit done;
    @(negedge clk);
    wi8 = w;
    wv8 = 1'b1;
    n = 0;
    while (!rdy8 && n < 40) begin @(negedge clk); n++; end
    chk("accept_in_bound", 32'(n < 40), 1);
    hs_cyc = cyc;
    done = 0;
    bits = '0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      wv8 = toggle ? i[0] : 1'b0;
      if (toggle) wi8 = 8'($urandom);
      if (fault && !done && mq8) begin kill = 1'b1; done = 1; end
      else kill = 1'b0;
      chk("busy_ready_low", rdy8, 0);
      if (i == 1) chk("clr_det_reset", dr8, 1);
      if (i >= 2 && i <= 9) bits[9-i] = din8;
      if (i == 11) begin
        chk("count_valid_at_11", cv8, 1);
        chk("match_count", mc8, ec);
        chk("consist_err", ce8, ee);
      end else chk("count_valid_early", cv8, 0);
    end
    kill = 1'b0;
    wv8 = 1'b0;
    chk("det_din_seq", bits, w);
  endtask

  typedef struct {logic [7:0] w; logic [3:0] c; logic e;} vec_t;
  vec_t tbl[4];

  initial begin
    int prev, n;
    tbl[0] = '{8'b10110110, 4'd2, 1'b0};
    tbl[1] = '{8'h00, 4'd0, 1'b0};
    tbl[2] = '{8'hFF, 4'd0, 1'b0};
    tbl[3] = '{8'b10111011, 4'd2, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_det_reset", dr8, 1);
    chk("rst_ready", rdy8, 1);
    chk("rst_det_din", din8, 0);
    chk("rst_count_valid", cv8, 0);
    chk("rst_match_count", mc8, 0);
    chk("rst_consist_err", ce8, 0);
    chk("rst_match_count16", mc16, 0);
    reset = 1'b0;

    prev = 0;
    for (int k = 0; k < 4; k++) begin
      send(tbl[k].w, tbl[k].c, tbl[k].e, 0, 0);
      if (k > 0) chk("back_to_back_spacing", hs_cyc - prev, 12);
      prev = hs_cyc;
    end

    send(8'b10110110, 4'd2, 1'b0, 0, 1);
    send(8'b10110110, 4'd2, 1'b1, 1, 0);

    @(negedge clk);
    wi8 = 8'b10110110;
    wv8 = 1'b1;
    chk("rstseq_ready", rdy8, 1);
    @(negedge clk);
    wv8 = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1 chk("rstseq_det_reset", dr8, 1);
    @(negedge clk);
    reset = 1'b0;
    chk("rstseq_idle_ready", rdy8, 1);
    chk("rstseq_match_cleared", mc8, 0);
    chk("rstseq_err_cleared", ce8, 0);
    n = 0;
    repeat (12) begin @(negedge clk); if (cv8) n++; end
    chk("rstseq_no_count_valid", n, 0);
    send(8'b00001011, 4'd1, 1'b0, 0, 0);

    @(negedge clk);
    wi16 = 16'hBBBB;
    wv16 = 1'b1;
    chk("w16_ready", rdy16, 1);
    @(negedge clk);
    wv16 = 1'b0;
    n = 1;
    while (!cv16 && n < 40) begin @(negedge clk); n++; end
    chk("w16_latency", n, 19);
    chk("w16_saturated_count", mc16, 3);
    chk("w16_consist_err", ce16, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
